// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer with valid/ready request and result handshakes.
// Define SHIFT_SEQ_STEP4_EN to move up to four positions per SHIFT cycle instead of one.
module shift_sequencer #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_cnt,
  input  logic [1:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never depends on ready, and payloads are held stable while valid.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

`ifdef SHIFT_SEQ_STEP4_EN
  localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'(4);
`else
  localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'(1);
`endif

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [1:0]          op_q, op_d;
  logic [CNT_W-1:0]    step;
  logic                accept;

  // Rotations shift a doubled copy so the bits leaving one end reappear at the other.
  function automatic logic [DATA_W-1:0] shift_val(input logic [DATA_W-1:0] d,
                                                   input logic [1:0]        op,
                                                   input logic [CNT_W-1:0]  amt);
    logic [2*DATA_W-1:0] dbl;
    logic [DATA_W-1:0]   res;
    dbl = {d, d};
    res = d;
    case (op)
      OP_ROL: begin
        dbl = dbl << amt;
        res = dbl[2*DATA_W-1:DATA_W];
      end
      OP_SLL: res = d << amt;
      OP_ROR: begin
        dbl = dbl >> amt;
        res = dbl[DATA_W-1:0];
      end
      OP_SRL: res = d >> amt;
      default: res = d;
    endcase
    return res;
  endfunction

  always_comb begin
    in_ready  = (state_q == IDLE) && rst_n;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_data  = data_q;
    accept    = in_valid && in_ready;
    step      = (rem_q > STEP_MAX) ? STEP_MAX : rem_q;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = in_data;
          op_d    = in_op;
          rem_d   = in_cnt;
          state_d = (in_cnt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_d = shift_val(data_q, op_q, step);
        rem_d  = rem_q - step;
        if (rem_q == step) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer; latencies follow SHIFT_SEQ_STEP4_EN.
module tb_shift_sequencer;

`ifdef SHIFT_SEQ_STEP4_EN
  localparam bit STEP4 = 1'b1;
`else
  localparam bit STEP4 = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  shift_sequencer #(.DATA_W(16), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one request, waits for the result, checks latency and data, then hands it off.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] d,
                        input logic [3:0] c, input logic [15:0] exp_d,
                        input int lat_off, input int lat_on);
    int n;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_cnt   = c;
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
    in_cnt   = ~c;
    in_op    = ~op;
    n = 1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check_eq({tag, "_latency"}, 32'(n), 32'(STEP4 ? lat_on : lat_off));
    check_eq({tag, "_data"}, 32'(out_data), 32'(exp_d));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_cnt    = '0;
    in_op     = '0;
    out_ready = 1'b0;

    repeat (3) tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'h0000);
    rst_n = 1'b1;
    #1;

    // ROL, SRL full span, and a wrap-around rotate
    run_op("rol1", 2'b00, 16'h8001, 4'd1, 16'h0003, 2, 2);
    run_op("srl15", 2'b11, 16'h8000, 4'd15, 16'h0001, 16, 5);
    run_op("rol15", 2'b00, 16'h0001, 4'd15, 16'h8000, 16, 5);
    run_op("ror5", 2'b10, 16'h0021, 4'd5, 16'h0801, 6, 3);

    // Zero count: result in cycle 1, busy exactly one cycle
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = 2'b10;
    in_data   = 16'h1234;
    in_cnt    = 4'd0;
    tick();
    in_valid = 1'b0;
    check_eq("ror0_valid", 32'(out_valid), 32'd1);
    check_eq("ror0_data", 32'(out_data), 32'h1234);
    check_eq("ror0_busy1", 32'(busy), 32'd1);
    tick();
    check_eq("ror0_busy2", 32'(busy), 32'd0);
    check_eq("ror0_valid2", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Back-pressure with an ignored request pulsed during DONE
    in_valid = 1'b1;
    in_op    = 2'b10;
    in_data  = 16'h0001;
    in_cnt   = 4'd4;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check_eq("bp_latency", 32'(n), 32'(STEP4 ? 2 : 5));
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_op    = 2'b01;
      in_data  = 16'hABCD;
      in_cnt   = 4'd1;
      check_eq("bp_data", 32'(out_data), 32'h1000);
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    check_eq("bp_data_end", 32'(out_data), 32'h1000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("bp_busy_after", 32'(busy), 32'd0);
    tick();
    check_eq("bp_no_second", 32'(busy | out_valid), 32'd0);

    // Reset during SHIFT discards the operation
    in_valid = 1'b1;
    in_op    = 2'b01;
    in_data  = 16'hFFFF;
    in_cnt   = 4'd8;
    tick();
    in_valid = 1'b0;
    tick();
    check_eq("rstmid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rstmid_valid", 32'(out_valid), 32'd0);
    check_eq("rstmid_busy", 32'(busy), 32'd0);
    check_eq("rstmid_data", 32'(out_data), 32'h0000);
    check_eq("rstmid_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    seen  = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid || busy) seen++;
    end
    out_ready = 1'b0;
    check_eq("rstmid_no_result", 32'(seen), 32'd0);

    // Back-to-back: second accept in the cycle after the first handoff
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = 2'b00;
    in_data   = 16'h00F0;
    in_cnt    = 4'd4;
    tick();
    in_op   = 2'b01;
    in_data = 16'h0001;
    in_cnt  = 4'd3;
    n = 1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check_eq("b2b_lat1", 32'(n), 32'(STEP4 ? 2 : 5));
    check_eq("b2b_data1", 32'(out_data), 32'h0F00);
    tick();
    check_eq("b2b_ready_after", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("b2b_accepted", 32'(busy), 32'd1);
    n = 1;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check_eq("b2b_lat2", 32'(n), 32'(STEP4 ? 2 : 4));
    check_eq("b2b_data2", 32'(out_data), 32'h0008);
    tick();
    out_ready = 1'b0;
    check_eq("b2b_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
